a_mvm_ctrl: RTL and testbench

- Sequencer and multiply-accumulate stage directly downstream of the A-matrix ROM top.
- Waits for aload_done, then accepts a 4-element input vector x.
- Walks rom_addr across all 16 ROM words and computes y = A·x for the 8×4 matrix A.
- Emits the 8 results one row at a time over a valid/ready handshake.

---
 rtl/a_mvm_ctrl_pkg.sv | 33 +++
 rtl/a_mvm_ctrl_if.sv | 24 ++
 rtl/a_mvm_ctrl_dot2.sv | 23 ++
 rtl/a_mvm_ctrl.sv | 150 +++++++++++++++
 tb/tb_a_mvm_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/a_mvm_ctrl_pkg.sv
// Shared sizes, FSM encoding and ROM word layout for the A-matrix MVM controller.
package a_mvm_ctrl_pkg;

   localparam int A_W    = 7;
   localparam int X_W    = 8;
   localparam int ACC_W  = 17;
   localparam int ROWS   = 8;
   localparam int COLS   = 4;
   localparam int ROM_AW = 4;

   localparam int ROM_W  = 2 * A_W;
   localparam int ROW_W  = 3;
   localparam int XV_W   = COLS * X_W;
   localparam int PROD_W = A_W + X_W;

   // Each ROM word carries two adjacent coefficients of one row.
   localparam int A0_LSB = 0;
   localparam int A1_LSB = A_W;

   typedef enum logic [2:0] {
      IDLE,
      ADDR0,
      ADDR1,
      LAST,
      OUT
   } state_e;

   // Pick element c out of the packed x vector.
   function automatic logic [X_W-1:0] x_elem(input logic [XV_W-1:0] x, input int c);
      return x[c*X_W +: X_W];
   endfunction

endpackage

// File: rtl/a_mvm_ctrl_if.sv
// Start/vector and result handshake bundle of the MVM controller.
interface a_mvm_ctrl_if;
   import a_mvm_ctrl_pkg::*;

   logic              start;
   logic [XV_W-1:0]   x_in;
   logic              start_ready;
   logic              y_valid;
   logic              y_ready;
   logic [ACC_W-1:0]  y_data;
   logic [ROW_W-1:0]  y_row;
   logic              done;

   modport master (
      output start, x_in, y_ready,
      input  start_ready, y_valid, y_data, y_row, done
   );

   modport slave (
      input  start, x_in, y_ready,
      output start_ready, y_valid, y_data, y_row, done
   );

endinterface

// File: rtl/a_mvm_ctrl_dot2.sv
// Combinational two-term multiply-accumulate: acc_in + a0*x0 + a1*x1, all unsigned.
module a_mvm_dot2
   import a_mvm_ctrl_pkg::*;
(
   input  logic [ACC_W-1:0] acc_in,
   input  logic [A_W-1:0]   a0,
   input  logic [A_W-1:0]   a1,
   input  logic [X_W-1:0]   x0,
   input  logic [X_W-1:0]   x1,
   output logic [ACC_W-1:0] acc_out
);

   logic [PROD_W-1:0] p0;
   logic [PROD_W-1:0] p1;

   // Operands are widened to the product width so nothing truncates before the sum.
   always_comb begin
      p0      = {{X_W{1'b0}}, a0} * {{A_W{1'b0}}, x0};
      p1      = {{X_W{1'b0}}, a1} * {{A_W{1'b0}}, x1};
      acc_out = acc_in + ACC_W'(p0) + ACC_W'(p1);
   end

endmodule

// File: rtl/a_mvm_ctrl.sv
// Sequencer for y = A*x: walks the A ROM two words per row and streams 8 results.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an accepted start (needs aload_done)
// ADDR0 | rom_addr = 2*row presented to the ROM
// ADDR1 | rom_addr = 2*row+1; first half of the row dot product
// LAST  | second half of the dot product, result registered
// OUT   | y_valid held until y_ready; then next row or back to IDLE
module a_mvm_ctrl
   import a_mvm_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              aload_done,
   input  logic [ROM_W-1:0]  A_input,
   output logic [ROM_AW-1:0] rom_addr,
   a_mvm_ctrl_if.slave       bus
);

   state_e             state_q,    state_d;
   logic [ROW_W-1:0]   row_q,      row_d;
   logic [XV_W-1:0]    x_q,        x_d;
   logic [ACC_W-1:0]   acc_q,      acc_d;
   logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
   logic               y_valid_q,  y_valid_d;
   logic [ACC_W-1:0]   y_data_q,   y_data_d;
   logic [ROW_W-1:0]   y_row_q,    y_row_d;
   logic               done_q,     done_d;

   logic               start_ready;
   logic [ROW_W-1:0]   row_inc;
   logic [ACC_W-1:0]   mac_acc_in;
   logic [X_W-1:0]     mac_x0;
   logic [X_W-1:0]     mac_x1;
   logic [ACC_W-1:0]   mac_out;

   assign start_ready = (state_q == IDLE) && aload_done;
   assign row_inc     = row_q + 3'd1;

   // The single MAC serves x[0..1] in ADDR1 and x[2..3] on top of acc in LAST.
   always_comb begin
      mac_acc_in = '0;
      mac_x0     = x_elem(x_q, 0);
      mac_x1     = x_elem(x_q, 1);
      if (state_q == LAST) begin
         mac_acc_in = acc_q;
         mac_x0     = x_elem(x_q, 2);
         mac_x1     = x_elem(x_q, 3);
      end
   end

   a_mvm_dot2 u_dot2 (
      .acc_in  (mac_acc_in),
      .a0      (A_input[A0_LSB +: A_W]),
      .a1      (A_input[A1_LSB +: A_W]),
      .x0      (mac_x0),
      .x1      (mac_x1),
      .acc_out (mac_out)
   );

   // Next-state and datapath updates; rom_addr is loaded one state ahead so the
   // registered ROM data lines up with ADDR1 and LAST.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      x_d        = x_q;
      acc_d      = acc_q;
      rom_addr_d = rom_addr_q;
      y_valid_d  = y_valid_q;
      y_data_d   = y_data_q;
      y_row_d    = y_row_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start && start_ready) begin
               x_d        = bus.x_in;
               row_d      = '0;
               acc_d      = '0;
               rom_addr_d = '0;
               state_d    = ADDR0;
            end
         end
         ADDR0: begin
            rom_addr_d = {row_q, 1'b1};
            state_d    = ADDR1;
         end
         ADDR1: begin
            acc_d   = mac_out;
            state_d = LAST;
         end
         LAST: begin
            y_data_d  = mac_out;
            y_row_d   = row_q;
            y_valid_d = 1'b1;
            state_d   = OUT;
         end
         OUT: begin
            if (bus.y_ready) begin
               y_valid_d = 1'b0;
               if (row_q == ROW_W'(ROWS - 1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  row_d      = row_inc;
                  rom_addr_d = {row_inc, 1'b0};
                  state_d    = ADDR0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any run in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         row_q      <= '0;
         x_q        <= '0;
         acc_q      <= '0;
         rom_addr_q <= '0;
         y_valid_q  <= 1'b0;
         y_data_q   <= '0;
         y_row_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         x_q        <= x_d;
         acc_q      <= acc_d;
         rom_addr_q <= rom_addr_d;
         y_valid_q  <= y_valid_d;
         y_data_q   <= y_data_d;
         y_row_q    <= y_row_d;
         done_q     <= done_d;
      end
   end

   assign rom_addr        = rom_addr_q;
   assign bus.start_ready = start_ready;
   assign bus.y_valid     = y_valid_q;
   assign bus.y_data      = y_data_q;
   assign bus.y_row       = y_row_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_a_mvm_ctrl.sv
// Randomised self-checking bench for a_mvm_ctrl against a plain-arithmetic y = A*x model.
module tb_a_mvm_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        aload_done = 1'b0;
   logic [13:0] A_input;
   logic [3:0]  rom_addr;

   a_mvm_ctrl_if bus();

   a_mvm_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .aload_done (aload_done),
      .A_input    (A_input),
      .rom_addr   (rom_addr),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Synchronous-read ROM: data for an address appears the cycle after it.
   logic [13:0] rom [16];
   always @(posedge clk) A_input <= rom[rom_addr];

   int a_m [8][4];
   int x_v [4];
   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] pack_x();
      logic [31:0] v;
      v = '0;
      for (int c = 0; c < 4; c++) v[8*c +: 8] = 8'(x_v[c]);
      return v;
   endfunction

   task automatic load_rom();
      for (int r = 0; r < 8; r++)
         for (int h = 0; h < 2; h++)
            rom[2*r+h] = {7'(a_m[r][2*h+1]), 7'(a_m[r][2*h])};
   endtask

   task automatic set_ramp();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 4; c++) a_m[r][c] = r + 1;
      for (int c = 0; c < 4; c++) x_v[c] = c + 1;
   endtask

   task automatic set_random();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 4; c++) a_m[r][c] = int'($urandom_range(0, 127));
      for (int c = 0; c < 4; c++) x_v[c] = int'($urandom_range(0, 255));
   endtask

   // mode 0: y_ready always high, mode 1: random y_ready, mode 2: 5-cycle stall at stall_row.
   task automatic run_vector(input int mode, input int stall_row, input bit poke);
      int exp_y [8];
      int idx, stall, first_valid, hs_last, done_cnt, bad, k;
      logic [3:0] addr_q [$];
      logic [3:0] last_addr;
      logic rdy;
      idx = 0; stall = 0; first_valid = -1; hs_last = -1; done_cnt = 0;
      for (int r = 0; r < 8; r++) begin
         exp_y[r] = 0;
         for (int c = 0; c < 4; c++) exp_y[r] += a_m[r][c] * x_v[c];
      end
      load_rom();
      @(negedge clk);
      checks++;
      if (bus.start_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_ready_before_run actual=%b required=1", bus.start_ready);
      end
      bus.x_in = pack_x();
      bus.start = 1'b1;
      bus.y_ready = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      bus.x_in = $urandom;
      addr_q.push_back(rom_addr);
      last_addr = rom_addr;
      for (k = 1; k < 600; k++) begin
         if (k > 1 && rom_addr !== last_addr) begin
            addr_q.push_back(rom_addr);
            last_addr = rom_addr;
         end
         if (bus.done === 1'b1) begin
            done_cnt++;
            checks++;
            if (k != hs_last + 1) begin
               errors++;
               $display("FAIL done_timing actual_cycle=%0d required_cycle=%0d", k, hs_last + 1);
            end
         end
         if (idx == 8 && k >= hs_last + 3) break;
         case (mode)
            0: rdy = 1'b1;
            1: rdy = 1'($urandom_range(0, 1));
            default: rdy = !(bus.y_valid === 1'b1 && idx == stall_row && stall < 5);
         endcase
         bus.y_ready = rdy;
         bus.start = poke && idx < 8 && (k % 3 == 0);
         if (poke) bus.x_in = $urandom;
         if (bus.y_valid === 1'b1) begin
            if (idx > 7) begin
               checks++;
               errors++;
               $display("FAIL extra_result actual_row=%0d required=none", bus.y_row);
            end else begin
               checks++;
               if (bus.y_data !== 17'(exp_y[idx])) begin
                  errors++;
                  $display("FAIL y_data row=%0d actual=%0d required=%0d", idx, bus.y_data, exp_y[idx]);
               end
               checks++;
               if (bus.y_row !== 3'(idx)) begin
                  errors++;
                  $display("FAIL y_row actual=%0d required=%0d", bus.y_row, idx);
               end
               if (first_valid < 0) first_valid = k;
               if (!rdy) begin
                  if (mode == 2 && idx == stall_row) begin
                     stall++;
                     checks++;
                     if (rom_addr !== 4'(2*idx+1)) begin
                        errors++;
                        $display("FAIL stall_rom_addr actual=%0d required=%0d", rom_addr, 2*idx+1);
                     end
                  end
               end else begin
                  if (idx == 7) hs_last = k;
                  idx++;
               end
            end
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.y_ready = 1'b0;
      checks++;
      if (idx != 8) begin
         errors++;
         $display("FAIL result_count actual=%0d required=8 (cycle budget expired)", idx);
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL done_count actual=%0d required=1", done_cnt);
      end
      bad = 0;
      if (addr_q.size() != 16) bad = 1;
      else for (int i = 0; i < 16; i++) if (addr_q[i] !== 4'(i)) bad = 1;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rom_addr_sequence actual_len=%0d required_len=16 first=%0d required_first=0",
                  addr_q.size(), addr_q.size() > 0 ? int'(addr_q[0]) : -1);
      end
      if (mode == 2) begin
         checks++;
         if (stall != 5) begin
            errors++;
            $display("FAIL stall_cycles actual=%0d required=5", stall);
         end
      end
      if (mode == 0) begin
         checks++;
         if (first_valid != 4) begin
            errors++;
            $display("FAIL first_valid_latency actual=%0d required=4", first_valid);
         end
         checks++;
         if (hs_last != 32) begin
            errors++;
            $display("FAIL last_handshake_cycle actual=%0d required=32", hs_last);
         end
      end
      checks++;
      if (bus.y_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_run_idle y_valid=%b start_ready=%b required=0,1", bus.y_valid, bus.start_ready);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      checks++;
      if (bus.y_valid !== 1'b0 || bus.y_data !== 17'd0 || bus.y_row !== 3'd0 ||
          bus.done !== 1'b0 || rom_addr !== 4'd0 || bus.start_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s actual v=%b d=%0d r=%0d done=%b addr=%0d sr=%b required all 0",
                  tag, bus.y_valid, bus.y_data, bus.y_row, bus.done, rom_addr, bus.start_ready);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 16; i++) rom[i] = '0;
      bus.start = 1'b0;
      bus.x_in = '0;
      bus.y_ready = 1'b0;
      aload_done = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_outputs");
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_outputs_zero("idle_without_aload");
      aload_done = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.start_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_ready_after_aload actual=%b required=1", bus.start_ready);
      end
   endtask

   task automatic test_reset_midrun();
      bit hit;
      hit = 1'b0;
      set_ramp();
      load_rom();
      @(negedge clk);
      bus.x_in = pack_x();
      bus.start = 1'b1;
      bus.y_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (bus.y_valid === 1'b1 && bus.y_row === 3'd3) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL reach_row3 actual=timeout required=row3_valid");
      end
      rst = 1'b0;
      aload_done = 1'b0;
      #1;
      check_outputs_zero("async_reset_midrun");
      @(negedge clk);
      rst = 1'b1;
      bus.x_in = pack_x();
      bus.start = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         check_outputs_zero("start_before_aload");
      end
      aload_done = 1'b1;
      bus.y_ready = 1'b0;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.x_in = '0;
      bus.y_ready = 1'b0;
      test_reset();
      test_reset_midrun();
      // Ramp matrix, nominal vector, full-rate timing.
      set_ramp();
      run_vector(0, 0, 1'b0);
      // Maximum operands.
      for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++) a_m[r][c] = 127;
      for (int c = 0; c < 4; c++) x_v[c] = 255;
      run_vector(0, 0, 1'b0);
      // Backpressure at row 2.
      set_ramp();
      for (int c = 0; c < 4; c++) x_v[c] = int'($urandom_range(0, 255));
      run_vector(2, 2, 1'b0);
      // Starts pulsed during the run with random x_in.
      set_random();
      run_vector(1, 0, 1'b1);
      // Back-to-back random vectors with random backpressure.
      for (int n = 0; n < 4; n++) begin
         set_random();
         run_vector(1, 0, 1'b0);
      end
      set_random();
      run_vector(0, 0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
